fifo_stream_reader: RTL and testbench

Downstream read-side stage for the synchronous FIFO. Converts the FIFO's registered-output read port into a valid/ready stream with one word per cycle sustained throughput. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer and an in-flight tracker. It never issues a read to an empty FIFO.

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/fifo_stream_skid.sv | 88 ++++++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 tb/tb_fifo_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO stream reader: buffer occupancy encoding and
// the helper that turns it into a word count.
package fifo_stream_pkg;

  // Number of words held in the output skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int OCC_MAX = 2;

  // The encoding is chosen so that the state value is the word count.
  function automatic logic [1:0] occ_count(input occ_t occ);
    return 2'(occ);
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order output buffer for the FIFO stream reader.
// push writes into the first slot that is free once this cycle's pop is applied;
// head is always the oldest buffered word.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no word buffered, head is stale
// ONE   | buf0 holds the only word
// TWO   | buf0 holds the oldest word, buf1 the next one
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output occ_t             occ,
  output logic [WIDTH-1:0] head
);

  occ_t             occ_q;
  occ_t             occ_nxt;
  logic [WIDTH-1:0] buf0_q;
  logic [WIDTH-1:0] buf0_nxt;
  logic [WIDTH-1:0] buf1_q;
  logic [WIDTH-1:0] buf1_nxt;

  // State and data registers; reset discards every buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= EMPTY;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      occ_q  <= occ_nxt;
      buf0_q <= buf0_nxt;
      buf1_q <= buf1_nxt;
    end
  end

  // Next occupancy and slot contents from (pop, push).
  always_comb begin
    occ_nxt  = occ_q;
    buf0_nxt = buf0_q;
    buf1_nxt = buf1_q;
    case (occ_q)
      EMPTY: begin
        // A pop cannot happen here because head is not valid.
        if (push) begin
          occ_nxt  = ONE;
          buf0_nxt = push_data;
        end
      end
      ONE: begin
        if (pop && !push) begin
          occ_nxt = EMPTY;
        end else if (pop && push) begin
          buf0_nxt = push_data;
        end else if (push) begin
          occ_nxt  = TWO;
          buf1_nxt = push_data;
        end
      end
      TWO: begin
        // push without pop would overflow; the issue logic upstream never
        // allows it, so the state saturates and the word is dropped.
        if (pop) begin
          buf0_nxt = buf1_q;
          if (push) begin
            buf1_nxt = push_data;
          end else begin
            occ_nxt = ONE;
          end
        end
      end
      default: begin
        occ_nxt = EMPTY;
      end
    endcase
  end

  assign occ  = occ_q;
  assign head = buf0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side stage for the synchronous FIFO: turns the registered-output read
// port into a valid/ready stream at one word per cycle. Reads are issued only
// when the FIFO is non-empty and the word can be guaranteed a buffer slot.
// Optional statistics (rd_count, underflow_err) are built when the macro
// FIFO_STREAM_STATS_EN is defined.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] rd_count,
  output logic                  underflow_err
`endif
);

  occ_t       occ;
  logic       pend;
  logic       pop;
  logic [2:0] level;

  assign m_valid = (occ != EMPTY);
  assign pop     = m_valid && m_ready;

  // Words that will be buffered after this edge if no new read is issued.
  // pop is only possible with occ >= 1, so this never goes negative.
  assign level = 3'(occ_count(occ)) + 3'(pend) - 3'(pop);

  assign fifo_rd_en = !rst && !fifo_empty && (level < 3'(OCC_MAX));

  // Tracks the read whose data appears on fifo_data_out next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
    end
  end

  fifo_stream_skid #(
    .WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (pend),
    .push_data(fifo_data_out),
    .pop      (pop),
    .occ      (occ),
    .head     (m_data)
  );

`ifdef FIFO_STREAM_STATS_EN
  // Delivered-word counter, wraps at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + 1'b1;
    end
  end

  // Sticky record of any FIFO underflow seen since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (fifo_underflow) begin
      underflow_err <= 1'b1;
    end
  end
`else
  // Without statistics the underflow flag and counter width have no use.
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  localparam int unused_stat_width = STAT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a behavioural
// FIFO (registered data_out, one-edge write latency) in front of it.
module tb_fifo_stream_reader;

  localparam int W      = 16;
  localparam int STAT_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
`ifdef FIFO_STREAM_STATS_EN
  logic [STAT_W-1:0] rd_count;
  logic              underflow_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .FIFO_WIDTH(W),
    .STAT_WIDTH(STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready)
`ifdef FIFO_STREAM_STATS_EN
    ,
    .rd_count      (rd_count),
    .underflow_err (underflow_err)
`endif
  );

  // Behavioural FIFO: words requested in ld_q are written on the next edge,
  // it is cleared with the reader's reset, and it can self-refill.
  logic [W-1:0] fq[$];
  logic [W-1:0] ld_q[$];
  logic         refill_en = 1'b0;
  logic [W-1:0] refill_val = 16'hC000;
  int           pushed_total = 0;
  int           rd_issued = 0;
  logic         uf_model;
  logic         uf_force = 1'b0;

  assign fifo_underflow = uf_model | uf_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
      uf_model      <= 1'b0;
    end else begin
      uf_model <= fifo_rd_en && (fq.size() == 0);
      if (fifo_rd_en) begin
        rd_issued++;
        if (fq.size() > 0) fifo_data_out <= fq.pop_front();
      end
      while (ld_q.size() > 0) fq.push_back(ld_q.pop_front());
      if (refill_en && fq.size() < 4) begin
        fq.push_back(refill_val);
        refill_val++;
        pushed_total++;
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic test_reset();
    logic         exp_rd[6];
    logic         exp_v[6];
    logic [W-1:0] exp_d[6];
    exp_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d  = '{16'h0000, 16'h0000, 16'h00A1, 16'h00A2, 16'h00A3, 16'h0000};
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++;
    if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
`ifdef FIFO_STREAM_STATS_EN
    n_checks++;
    if (rd_count !== '0) begin n_fail++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    n_checks++;
    if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow_err: got %b expected 0", underflow_err); end
`endif
    ld_q.push_back(16'h00A1);
    ld_q.push_back(16'h00A2);
    ld_q.push_back(16'h00A3);
    @(negedge clk);
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en_held: got %b expected 0", fifo_rd_en); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_rd_en !== exp_rd[k]) begin
        n_fail++; $display("FAIL first_burst_rd_en[%0d]: got %b expected %b", k, fifo_rd_en, exp_rd[k]);
      end
      n_checks++;
      if (m_valid !== exp_v[k]) begin
        n_fail++; $display("FAIL first_burst_valid[%0d]: got %b expected %b", k, m_valid, exp_v[k]);
      end else if (exp_v[k]) begin
        n_checks++;
        if (m_data !== exp_d[k]) begin
          n_fail++; $display("FAIL first_burst_data[%0d]: got %h expected %h", k, m_data, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int           rd_start;
    logic [W-1:0] words[5];
    words = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4, 16'h00B5};
    m_ready = 1'b0;
    @(negedge clk);
    rd_start = rd_issued;
    for (int i = 0; i < 5; i++) ld_q.push_back(words[i]);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h00B1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h expected valid=1 data=00b1", k, m_valid, m_data);
      end
    end
    n_checks++;
    if (rd_issued - rd_start != 2) begin
      n_fail++; $display("FAIL stall_reads: got %0d expected 2", rd_issued - rd_start);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_rd_en: got %b expected 0", fifo_rd_en); end
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== words[k]) begin
        n_fail++; $display("FAIL drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, m_valid, m_data, words[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid: got %b expected 0", m_valid); end
  endtask

  task automatic test_toggle();
    int popped = 0;
    refill_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      m_ready = (i < 40) ? ((i % 2) == 0) : 1'b1;
      if (i == 40) refill_en = 1'b0;
      #1;
      n_checks++;
      if (fifo_rd_en && fifo_empty) begin
        n_fail++; $display("FAIL toggle_read_empty[%0d]: got rd_en=1 with empty=1 expected rd_en=0", i);
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 16'hC000 + 16'(popped)) begin
          n_fail++; $display("FAIL toggle_order[%0d]: got %h expected %h", popped, m_data, 16'hC000 + 16'(popped));
        end
        popped++;
      end
    end
    n_checks++;
    if (popped != pushed_total || popped < 20) begin
      n_fail++; $display("FAIL toggle_count: got %0d popped expected %0d", popped, pushed_total);
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    m_ready = 1'b0;
    @(negedge clk);
    ld_q.push_back(16'h00E1);
    ld_q.push_back(16'h00E2);
    ld_q.push_back(16'h00E3);
    ld_q.push_back(16'h00E4);
    repeat (6) @(negedge clk);
    m_ready = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1 || m_data !== 16'h00E1) begin
      n_fail++; $display("FAIL mid_setup: got rd_en=%b data=%h expected rd_en=1 data=00e1", fifo_rd_en, m_data);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || m_data !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b rd_en=%b data=%h expected 0 0 0000", m_valid, fifo_rd_en, m_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: got valid=%b rd_en=%b expected 0 0", k, m_valid, fifo_rd_en);
      end
    end
    ld_q.push_back(16'h00F1);
    while (m_valid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h00F1) begin
      n_fail++; $display("FAIL mid_fresh: got valid=%b data=%h expected valid=1 data=00f1", m_valid, m_data);
    end
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_dup: got %b expected 0", m_valid); end
  endtask

`ifdef FIFO_STREAM_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) ld_q.push_back(16'h0100 + 16'(i));
    repeat (16) @(negedge clk);
    n_checks++;
    if (rd_count !== 4'd10) begin n_fail++; $display("FAIL stats_count10: got %0d expected 10", rd_count); end
    for (int i = 0; i < 6; i++) ld_q.push_back(16'h0200 + 16'(i));
    repeat (12) @(negedge clk);
    n_checks++;
    if (rd_count !== 4'd0) begin n_fail++; $display("FAIL stats_wrap: got %0d expected 0", rd_count); end
    n_checks++;
    if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL stats_uf_idle: got %b expected 0", underflow_err); end
    uf_force = 1'b1;
    @(negedge clk);
    uf_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL stats_uf_sticky[%0d]: got %b expected 1", k, underflow_err); end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (underflow_err !== 1'b0 || rd_count !== '0) begin
      n_fail++; $display("FAIL stats_clear: got uf=%b count=%0d expected 0 0", underflow_err, rd_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef FIFO_STREAM_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
